ttl_169_cascade_ctrl: RTL and testbench

//  Upstream sequencer for a cascade of STAGES ttl_74169 4-bit up/down counters used as a

---
 rtl/ttl_169_cascade_ctrl_pkg.sv | 20 ++
 rtl/ttl_169_cascade_ctrl.sv | 133 +++++++++++++
 tb/tb_ttl_169_cascade_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ttl_169_cascade_ctrl_pkg.sv
// ============================================================================
//  ttl_169_cascade_ctrl_pkg : shared state encodings and widths for the
//  74169 cascade sequencer.            Rev 1.0
// ============================================================================
`default_nettype none

package ttl_169_cascade_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_RELOAD = 2'd3
   } state_t;

   localparam int TC_COUNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/ttl_169_cascade_ctrl.sv
// ============================================================================
//  ttl_169_cascade_ctrl : sequences a chain of 74169 counters as a one-shot or
//  auto-reload divider, counting qualified terminal events.   Rev 1.0
// ============================================================================
`default_nettype none

module ttl_169_cascade_ctrl
   import ttl_169_cascade_ctrl_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    pause,
   input  logic                    auto_reload,
   input  logic                    dir_up,
   input  logic                    preset_we,
   input  logic [4*STAGES-1:0]     preset,
   input  logic                    rco_n_in,
   output logic                    load_n,
   output logic                    ent_n,
   output logic                    enp_n,
   output logic                    direction,
   output logic [4*STAGES-1:0]     P,
   output logic                    busy,
   output logic                    tc_pulse,
   output logic [TC_COUNT_W-1:0]   tc_count
);

   localparam int W = 4 * STAGES;

   state_t                  state_q, state_d;
   logic                    load_n_q, load_n_d;
   logic                    ent_n_q, ent_n_d;
   logic                    enp_n_q, enp_n_d;
   logic                    dir_q, dir_d;
   logic [W-1:0]            p_q, p_d;
   logic [W-1:0]            preset_q, preset_d;
   logic                    busy_q, busy_d;
   logic                    tc_pulse_q, tc_pulse_d;
   logic [TC_COUNT_W-1:0]   tc_count_q, tc_count_d;
   logic                    w_terminal;

   // rco_n is only trusted in RUN; the paused qualifier stops a held terminal re-firing
   assign w_terminal = (state_q == ST_RUN) && !rco_n_in && !pause;

   always_comb begin
      state_d    = state_q;
      load_n_d   = 1'b1;
      ent_n_d    = 1'b1;
      enp_n_d    = 1'b1;
      dir_d      = dir_q;
      p_d        = p_q;
      tc_pulse_d = 1'b0;
      tc_count_d = tc_count_q;
      preset_d   = preset_we ? preset : preset_q;

      if (stop) begin
         state_d = ST_IDLE;
      end else if (start) begin
         state_d = ST_LOAD;
         if (state_q == ST_IDLE) tc_count_d = '0;
      end else begin
         case (state_q)
            ST_LOAD, ST_RELOAD: state_d = ST_RUN;
            ST_RUN: begin
               if (w_terminal) begin
                  tc_pulse_d = 1'b1;
                  tc_count_d = tc_count_q + 1'b1;
                  state_d    = auto_reload ? ST_RELOAD : ST_IDLE;
               end
            end
            default: ;
         endcase
      end

      // Outputs follow the state being entered so every port is a flop
      case (state_d)
         ST_LOAD, ST_RELOAD: begin
            load_n_d = 1'b0;
            p_d      = preset_q;
            dir_d    = dir_up;
         end
         ST_RUN: begin
            ent_n_d = 1'b0;
            enp_n_d = pause;
         end
         default: ;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         load_n_q   <= 1'b1;
         ent_n_q    <= 1'b1;
         enp_n_q    <= 1'b1;
         dir_q      <= 1'b1;
         p_q        <= '0;
         preset_q   <= '0;
         busy_q     <= 1'b0;
         tc_pulse_q <= 1'b0;
         tc_count_q <= '0;
      end else begin
         state_q    <= state_d;
         load_n_q   <= load_n_d;
         ent_n_q    <= ent_n_d;
         enp_n_q    <= enp_n_d;
         dir_q      <= dir_d;
         p_q        <= p_d;
         preset_q   <= preset_d;
         busy_q     <= busy_d;
         tc_pulse_q <= tc_pulse_d;
         tc_count_q <= tc_count_d;
      end
   end

   assign load_n    = load_n_q;
   assign ent_n     = ent_n_q;
   assign enp_n     = enp_n_q;
   assign direction = dir_q;
   assign P         = p_q;
   assign busy      = busy_q;
   assign tc_pulse  = tc_pulse_q;
   assign tc_count  = tc_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ttl_169_cascade_ctrl.sv
// ============================================================================
//  tb_ttl_169_cascade_ctrl : drives the sequencer into a behavioural 74169
//  chain; terminal events are predicted from period arithmetic.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_ttl_169_cascade_ctrl;
   import ttl_169_cascade_ctrl_pkg::*;

   localparam int STAGES = 2;
   localparam int W      = 4 * STAGES;

   logic clk = 1'b0;
   logic rst, start, stop, pause, auto_reload, dir_up, preset_we;
   logic [W-1:0] preset;
   logic rco_n_in, load_n, ent_n, enp_n, direction, busy, tc_pulse;
   logic [W-1:0] P;
   logic [TC_COUNT_W-1:0] tc_count;

   always #50 clk = ~clk;

   ttl_169_cascade_ctrl #(.STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .auto_reload(auto_reload), .dir_up(dir_up), .preset_we(preset_we),
      .preset(preset), .rco_n_in(rco_n_in), .load_n(load_n), .ent_n(ent_n),
      .enp_n(enp_n), .direction(direction), .P(P), .busy(busy),
      .tc_pulse(tc_pulse), .tc_count(tc_count)
   );

   // Chain: stage carries cascade in the counting direction, terminal is all-ones
   logic [3:0]   q [STAGES];
   logic         carry_n [STAGES];
   logic [W-1:0] chain;
   logic         chain_rco_n, ovr_en, ovr_val;

   assign carry_n[0] = ent_n;
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign chain[4*k +: 4] = q[k];
      if (k < STAGES - 1) begin : g_carry
         assign carry_n[k+1] = !(!carry_n[k] && (direction ? (q[k] == 4'hF) : (q[k] == 4'h0)));
      end
      always @(posedge clk) begin
         if (!load_n)                      q[k] <= P[4*k +: 4];
         else if (!enp_n && !carry_n[k])   q[k] <= direction ? q[k] + 4'd1 : q[k] - 4'd1;
      end
   end
   assign chain_rco_n = !load_n ? 1'b0 : !(!ent_n && (chain == {W{1'b1}}));
   assign rco_n_in    = ovr_en ? ovr_val : chain_rco_n;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   bit mon_en   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: each run is a load edge plus the edge after which the chain shows all-ones
   typedef struct { int edge_n; int cnt; } exp_t;
   exp_t exp_q[$];
   bit   m_active, m_dir;
   int   m_load_edge, m_ff_edge, m_count, m_preg, m_p;
   bit   prev_pause;

   function automatic int period(int p, bit up);
      if (up) return (1 << W) - p + 1;
      return (p == (1 << W) - 1) ? 2 : p + 3;
   endfunction

   function automatic void do_load(int n);
      m_active    = 1;
      m_load_edge = n;
      m_p         = m_preg;
      m_dir       = dir_up;
      m_ff_edge   = n + period(m_preg, dir_up) - 1;
   endfunction

   function automatic void model_step(int n);
      if (rst) begin
         m_active = 0; m_count = 0; m_preg = 0; m_p = 0; m_dir = 1;
         return;
      end
      if (stop) m_active = 0;
      else if (start) begin
         if (!m_active) m_count = 0;
         do_load(n);
      end else if (m_active && n >= m_load_edge + 2 && n > m_ff_edge && !pause) begin
         m_count = (m_count + 1) % 256;
         exp_q.push_back('{edge_n: n, cnt: m_count});
         if (auto_reload) do_load(n);
         else m_active = 0;
      end else if (m_active && n >= m_load_edge + 1 && pause && n < m_ff_edge) begin
         m_ff_edge++;
      end
      if (preset_we) m_preg = int'(preset);
   endfunction

   task automatic tick();
      model_step(cyc + 1);
      prev_pause = pause;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // Monitor: scoreboard for pulses, plus per-cycle status against the model
   always @(posedge clk) begin
      #20;
      if (mon_en) begin
         if (tc_pulse) begin
            if (exp_q.size() == 0) chk("unexpected_tc_pulse", tc_pulse, 1'b0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("tc_pulse_edge", cyc, e.edge_n);
               chk("tc_count_at_pulse", tc_count, e.cnt);
            end
         end else if (exp_q.size() != 0 && exp_q[0].edge_n <= cyc) begin
            void'(exp_q.pop_front());
            chk("missing_tc_pulse", tc_pulse, 1'b1);
         end
         chk("busy", busy, m_active);
         chk("tc_count", tc_count, m_count);
         chk("load_n", load_n, !(m_active && cyc == m_load_edge));
         if (m_active && cyc == m_load_edge) begin
            chk("P_on_load", P, m_p);
            chk("direction_on_load", direction, m_dir);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   int  s;
   bit  want_pause;

   initial begin
      rst = 1; start = 0; stop = 0; pause = 0; auto_reload = 0; dir_up = 1;
      preset_we = 0; preset = '0; ovr_en = 0; ovr_val = 1; prev_pause = 0;
      tick(); tick();
      chk("rst_load_n", load_n, 1);    chk("rst_ent_n", ent_n, 1);
      chk("rst_enp_n", enp_n, 1);      chk("rst_direction", direction, 1);
      chk("rst_P", P, 0);              chk("rst_busy", busy, 0);
      chk("rst_tc_pulse", tc_pulse, 0); chk("rst_tc_count", tc_count, 0);
      rst = 0; mon_en = 1;

      // Idle: a toggling rco_n must not produce events
      ovr_en = 1;
      for (int i = 0; i < 6; i++) begin ovr_val = i[0]; tick(); end
      ovr_en = 0;
      chk("idle_tc_count", tc_count, 0);

      // Up, auto-reload from F0: 17-cycle period
      preset = 8'hF0; preset_we = 1; tick(); preset_we = 0;
      dir_up = 1; auto_reload = 1;
      start = 1; tick(); start = 0; s = cyc;
      tick();
      chk("up_chain_after_load", chain, 8'hF0);
      while (cyc < s + 51) tick();
      chk("up_three_events", tc_count, 3);
      stop = 1; tick(); stop = 0;

      // Down, one-shot from 05: event 8 edges after start, chain left at FE
      preset = 8'h05; preset_we = 1; tick(); preset_we = 0;
      dir_up = 0; auto_reload = 0;
      start = 1; tick(); start = 0; s = cyc;
      while (cyc < s + 9) tick();
      chk("down_oneshot_busy", busy, 0);
      chk("down_oneshot_count", tc_count, 1);
      chk("down_chain_final", chain, 8'hFE);

      // Pause held at FF for 10 edges, then exactly one event
      preset = 8'hF0; preset_we = 1; tick(); preset_we = 0;
      dir_up = 1; auto_reload = 0;
      start = 1; tick(); start = 0; s = cyc;
      while (cyc < s + 30) begin
         pause = (cyc + 1 >= s + 16) && (cyc + 1 <= s + 25);
         tick();
      end
      pause = 0;
      chk("pause_single_event", tc_count, 1);
      chk("pause_idle_after", busy, 0);

      // Preset rewrite mid-run affects only the next reload
      auto_reload = 1;
      start = 1; tick(); start = 0; s = cyc;
      while (cyc < s + 5) tick();
      preset = 8'h80; preset_we = 1; tick(); preset_we = 0;
      while (cyc < s + 146) tick();
      chk("preset_change_events", tc_count, 2);
      stop = 1; tick(); stop = 0;

      // start+stop together in RUN: stop wins
      preset = 8'hF0; preset_we = 1; tick(); preset_we = 0;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 5; i++) tick();
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      chk("start_stop_busy", busy, 0);

      // Async reset in the RELOAD cycle
      start = 1; tick(); start = 0; s = cyc;
      while (cyc < s + 17) tick();
      #10 rst = 1;
      #1;
      chk("async_rst_load_n", load_n, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_tc_pulse", tc_pulse, 0);
      chk("async_rst_tc_count", tc_count, 0);
      tick();
      rst = 0;

      // Randomised operation
      want_pause = 0;
      for (int i = 0; i < 4000; i++) begin
         int n;
         n = cyc + 1;
         stop        = ($urandom_range(0, 399) == 0);
         start       = m_active ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 5) == 0);
         dir_up      = $urandom_range(0, 1);
         preset_we   = ($urandom_range(0, 39) == 0);
         preset      = W'($urandom);
         if ($urandom_range(0, 99) == 0) auto_reload = ~auto_reload;
         if ($urandom_range(0, 29) == 0) want_pause = ~want_pause;
         pause = want_pause;
         if (m_active && n > m_ff_edge && !prev_pause) pause = 0;
         tick();
      end
      start = 0; pause = 0; preset_we = 0;
      stop = 1; tick(); stop = 0;
      tick(); tick();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
